// File: rtl/force_capture_buffer_if.sv
// force_capture_buffer_if
//   Groups the force-pipeline capture inputs, the readback port and the status outputs of
//   force_capture_buffer into one bundle. The master side (pipeline + test control) drives arm, the
//   force triple, valid/done and read requests. The slave side (the capture buffer) returns read data
//   and status.
//
//   capture : arm, in_force_x/y/z, in_valid, in_done
//   readback: rd_en, rd_addr -> rd_valid, rd_force_x/y/z
//   status  : wr_count, overflow, capture_done, checksum
interface force_capture_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  arm;
    logic [DATA_WIDTH-1:0] in_force_x;
    logic [DATA_WIDTH-1:0] in_force_y;
    logic [DATA_WIDTH-1:0] in_force_z;
    logic                  in_valid;
    logic                  in_done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_force_x;
    logic [DATA_WIDTH-1:0] rd_force_y;
    logic [DATA_WIDTH-1:0] rd_force_z;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  overflow;
    logic                  capture_done;
    logic [DATA_WIDTH-1:0] checksum;

    modport master (
        output arm, in_force_x, in_force_y, in_force_z, in_valid, in_done, rd_en, rd_addr,
        input  rd_valid, rd_force_x, rd_force_y, rd_force_z, wr_count, overflow, capture_done,
               checksum
    );

    modport slave (
        input  arm, in_force_x, in_force_y, in_force_z, in_valid, in_done, rd_en, rd_addr,
        output rd_valid, rd_force_x, rd_force_y, rd_force_z, wr_count, overflow, capture_done,
               checksum
    );
endinterface

// File: rtl/force_capture_buffer.sv
// force_capture_buffer
//   Test sink for the LJ force pipeline. Every valid (x, y, z) force triple is stored in order.
//   The buffer counts the stored triples and keeps a sticky overflow flag for triples dropped while
//   full. It also keeps a running XOR checksum of x^y^z over the stored triples. A registered read
//   port lets test logic dump the captured triples once the pipeline reports done.
//
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : force_capture_buffer_if.slave carrying capture inputs, read port and status
//
//   state      | meaning
//   -----------+---------------------------------------------------------------
//   ST_IDLE    | after reset; waits for arm, ignores valid/done
//   ST_CAPTURE | storing valid triples until in_done
//   ST_DONE    | capture finished, capture_done high; waits for re-arm
module force_capture_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    force_capture_buffer_if.slave   bus
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_CAPTURE = 2'b01;
    localparam logic [1:0] ST_DONE    = 2'b10;

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_COUNT  = (ADDR_WIDTH + 1)'(1);

    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] checksum;

    logic [DATA_WIDTH-1:0] mem_x [DEPTH];
    logic [DATA_WIDTH-1:0] mem_y [DEPTH];
    logic [DATA_WIDTH-1:0] mem_z [DEPTH];

    logic                  full;
    logic                  capturing;
    logic                  wr_fire;
    logic                  drop_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_in_range;

    // arm takes priority over everything in the same cycle, so a triple
    // arriving with arm never lands in the freshly cleared capture.
    assign full      = (wr_count == FULL_COUNT);
    assign capturing = (state == ST_CAPTURE) && !bus.arm;
    assign wr_fire   = capturing && bus.in_valid && !full;
    assign drop_fire = capturing && bus.in_valid && full;
    assign wr_addr   = wr_count[ADDR_WIDTH-1:0];

    // Compared against the pre-write count, so a read of the slot being
    // written this cycle (or any older-capture leftover) returns zero.
    assign rd_in_range = ({1'b0, bus.rd_addr} < wr_count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wr_count <= '0;
            overflow <= 1'b0;
            checksum <= '0;
        end else if (bus.arm) begin
            state    <= ST_CAPTURE;
            wr_count <= '0;
            overflow <= 1'b0;
            checksum <= '0;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    if (wr_fire) begin
                        wr_count <= wr_count + ONE_COUNT;
                        checksum <= checksum ^ bus.in_force_x ^ bus.in_force_y ^ bus.in_force_z;
                    end
                    if (drop_fire) begin
                        overflow <= 1'b1;
                    end
                    if (bus.in_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_IDLE: state <= ST_IDLE;
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage is not reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_x[wr_addr] <= bus.in_force_x;
            mem_y[wr_addr] <= bus.in_force_y;
            mem_z[wr_addr] <= bus.in_force_z;
        end
    end

    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_x_q;
    logic [DATA_WIDTH-1:0] rd_y_q;
    logic [DATA_WIDTH-1:0] rd_z_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            rd_z_q     <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                if (rd_in_range) begin
                    rd_x_q <= mem_x[bus.rd_addr];
                    rd_y_q <= mem_y[bus.rd_addr];
                    rd_z_q <= mem_z[bus.rd_addr];
                end else begin
                    rd_x_q <= '0;
                    rd_y_q <= '0;
                    rd_z_q <= '0;
                end
            end
        end
    end

    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_force_x   = rd_x_q;
    assign bus.rd_force_y   = rd_y_q;
    assign bus.rd_force_z   = rd_z_q;
    assign bus.wr_count     = wr_count;
    assign bus.overflow     = overflow;
    assign bus.capture_done = (state == ST_DONE);
    assign bus.checksum     = checksum;

endmodule

// File: tb/tb_force_capture_buffer.sv
module tb_force_capture_buffer;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    force_capture_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    force_capture_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge and outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.arm        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_done    = 1'b0;
        bus.in_force_x = '0;
        bus.in_force_y = '0;
        bus.in_force_z = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
        bus.in_valid   = 1'b1;
        bus.in_force_x = x;
        bus.in_force_y = y;
        bus.in_force_z = z;
        tick();
        bus.in_valid   = 1'b0;
    endtask

    task automatic finish_capture();
        bus.in_done = 1'b1;
        tick();
        bus.in_done = 1'b0;
    endtask

    task automatic read_entry(input logic [AW-1:0] a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
        total++; if (bus.wr_count !== 9'd0) begin bad++; $display("FAIL reset_wr_count got=%0d want=0", bus.wr_count); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
        total++; if (bus.capture_done !== 1'b0) begin bad++; $display("FAIL reset_capture_done got=%b want=0", bus.capture_done); end
        total++; if (bus.checksum !== 32'd0) begin bad++; $display("FAIL reset_checksum got=%h want=0", bus.checksum); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", bus.rd_valid); end
        total++; if (bus.rd_force_x !== 32'd0) begin bad++; $display("FAIL reset_rd_x got=%h want=0", bus.rd_force_x); end
        rst = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        bus.in_force_x = 32'd9;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.wr_count !== 9'd0) begin bad++; $display("FAIL idle_ignores_valid got=%0d want=0", bus.wr_count); end
    endtask

    task automatic test_basic();
        do_arm();
        total++; if (bus.wr_count !== 9'd0) begin bad++; $display("FAIL basic_arm_count got=%0d want=0", bus.wr_count); end
        push(32'd1, 32'd2, 32'd3);
        push(32'd4, 32'd5, 32'd6);
        total++; if (bus.checksum !== 32'd7) begin bad++; $display("FAIL basic_partial_checksum got=%h want=7", bus.checksum); end
        push(32'd7, 32'd8, 32'd9);
        total++; if (bus.capture_done !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%b want=0", bus.capture_done); end
        finish_capture();
        total++; if (bus.wr_count !== 9'd3) begin bad++; $display("FAIL basic_wr_count got=%0d want=3", bus.wr_count); end
        total++; if (bus.checksum !== 32'd1) begin bad++; $display("FAIL basic_checksum got=%h want=1", bus.checksum); end
        total++; if (bus.capture_done !== 1'b1) begin bad++; $display("FAIL basic_capture_done got=%b want=1", bus.capture_done); end
        read_entry(8'd1);
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL basic_rd_valid got=%b want=1", bus.rd_valid); end
        total++; if ({bus.rd_force_x, bus.rd_force_y, bus.rd_force_z} !== {32'd4, 32'd5, 32'd6})
            begin bad++; $display("FAIL basic_rd_data got=%0d,%0d,%0d want=4,5,6", bus.rd_force_x, bus.rd_force_y, bus.rd_force_z); end
        tick();
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL basic_rd_valid_drop got=%b want=0", bus.rd_valid); end
        total++; if (bus.rd_force_x !== 32'd4) begin bad++; $display("FAIL basic_rd_hold got=%0d want=4", bus.rd_force_x); end
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.wr_count !== 9'd3) begin bad++; $display("FAIL done_ignores_valid got=%0d want=3", bus.wr_count); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_sum;
        exp_sum = '0;
        do_arm();
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i == DEPTH) begin
                total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_exact_full got=%b want=0", bus.overflow); end
            end
            if (i < DEPTH) exp_sum = exp_sum ^ i ^ (i * 3) ^ (32'hA5A5_0000 + i);
            push(i, i * 3, 32'hA5A5_0000 + i);
        end
        total++; if (bus.wr_count !== 9'd256) begin bad++; $display("FAIL ovf_wr_count got=%0d want=256", bus.wr_count); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", bus.overflow); end
        total++; if (bus.checksum !== exp_sum) begin bad++; $display("FAIL ovf_checksum got=%h want=%h", bus.checksum, exp_sum); end
        finish_capture();
        read_entry(8'd255);
        total++; if ({bus.rd_force_x, bus.rd_force_y, bus.rd_force_z} !== {32'd255, 32'd765, 32'hA5A5_00FF})
            begin bad++; $display("FAIL ovf_entry255 got=%h,%h,%h want=ff,2fd,a5a500ff", bus.rd_force_x, bus.rd_force_y, bus.rd_force_z); end
        read_entry(8'd0);
        total++; if ({bus.rd_force_x, bus.rd_force_y, bus.rd_force_z} !== {32'd0, 32'd0, 32'hA5A5_0000})
            begin bad++; $display("FAIL ovf_entry0 got=%h,%h,%h want=0,0,a5a50000", bus.rd_force_x, bus.rd_force_y, bus.rd_force_z); end
        do_arm();
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_cleared_by_arm got=%b want=0", bus.overflow); end
    endtask

    task automatic test_valid_with_done();
        do_arm();
        bus.in_done = 1'b1;
        push(32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D);
        bus.in_done = 1'b0;
        total++; if (bus.wr_count !== 9'd1) begin bad++; $display("FAIL vd_wr_count got=%0d want=1", bus.wr_count); end
        total++; if (bus.capture_done !== 1'b1) begin bad++; $display("FAIL vd_capture_done got=%b want=1", bus.capture_done); end
        push(32'h1111_1111, 32'h2222_2222, 32'h4444_4444);
        total++; if (bus.wr_count !== 9'd1) begin bad++; $display("FAIL vd_late_valid got=%0d want=1", bus.wr_count); end
        total++; if (bus.checksum !== (32'hDEAD_BEEF ^ 32'h1234_5678 ^ 32'hCAFE_F00D))
            begin bad++; $display("FAIL vd_checksum got=%h want=%h", bus.checksum, 32'hDEAD_BEEF ^ 32'h1234_5678 ^ 32'hCAFE_F00D); end
        read_entry(8'd0);
        total++; if ({bus.rd_force_x, bus.rd_force_y, bus.rd_force_z} !== {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D})
            begin bad++; $display("FAIL vd_entry0 got=%h,%h,%h want=deadbeef,12345678,cafef00d", bus.rd_force_x, bus.rd_force_y, bus.rd_force_z); end
        read_entry(8'd1);
        total++; if ({bus.rd_valid, bus.rd_force_x} !== {1'b1, 32'd0})
            begin bad++; $display("FAIL vd_entry1_zero got=%b,%h want=1,0", bus.rd_valid, bus.rd_force_x); end
    endtask

    task automatic test_read_beyond();
        do_arm();
        for (int i = 0; i < 5; i++) push(32'd10 + i, 32'd20 + i, 32'd30 + i);
        finish_capture();
        total++; if (bus.wr_count !== 9'd5) begin bad++; $display("FAIL rb_wr_count got=%0d want=5", bus.wr_count); end
        read_entry(8'd4);
        total++; if (bus.rd_force_z !== 32'd34) begin bad++; $display("FAIL rb_last_entry got=%0d want=34", bus.rd_force_z); end
        read_entry(8'd7);
        total++; if ({bus.rd_valid, bus.rd_force_x, bus.rd_force_y, bus.rd_force_z} !== {1'b1, 96'd0})
            begin bad++; $display("FAIL rb_addr7 got=%b,%h,%h,%h want=1,0,0,0", bus.rd_valid, bus.rd_force_x, bus.rd_force_y, bus.rd_force_z); end
        do_arm();
        total++; if ({bus.wr_count, bus.overflow, bus.checksum} !== {9'd0, 1'b0, 32'd0})
            begin bad++; $display("FAIL rb_rearm got=%0d,%b,%h want=0,0,0", bus.wr_count, bus.overflow, bus.checksum); end
        read_entry(8'd0);
        total++; if (bus.rd_force_x !== 32'd0) begin bad++; $display("FAIL rb_rearm_read0 got=%0d want=0", bus.rd_force_x); end
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'd0;
        push(32'd77, 32'd78, 32'd79);
        bus.rd_en   = 1'b0;
        total++; if ({bus.rd_valid, bus.rd_force_x} !== {1'b1, 32'd0})
            begin bad++; $display("FAIL rb_same_cycle_rw got=%b,%0d want=1,0", bus.rd_valid, bus.rd_force_x); end
        read_entry(8'd0);
        total++; if (bus.rd_force_x !== 32'd77) begin bad++; $display("FAIL rb_after_rw got=%0d want=77", bus.rd_force_x); end
    endtask

    task automatic test_async_reset();
        do_arm();
        for (int i = 0; i < 10; i++) push(32'd100 + i, 32'd3, 32'd5);
        total++; if (bus.wr_count !== 9'd10) begin bad++; $display("FAIL ar_pre_count got=%0d want=10", bus.wr_count); end
        read_entry(8'd3);
        total++; if ({bus.rd_valid, bus.rd_force_x} !== {1'b1, 32'd103})
            begin bad++; $display("FAIL ar_pre_read got=%b,%0d want=1,103", bus.rd_valid, bus.rd_force_x); end
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'd2;
        tick();
        #2;
        rst = 1'b0;
        #1;
        total++; if ({bus.wr_count, bus.overflow, bus.capture_done, bus.checksum} !== 43'd0)
            begin bad++; $display("FAIL ar_status_async got=%0d,%b,%b,%h want=0,0,0,0", bus.wr_count, bus.overflow, bus.capture_done, bus.checksum); end
        total++; if ({bus.rd_valid, bus.rd_force_x, bus.rd_force_y, bus.rd_force_z} !== 97'd0)
            begin bad++; $display("FAIL ar_read_async got=%b,%h want=0,0", bus.rd_valid, bus.rd_force_x); end
        bus.rd_en = 1'b0;
        tick();
        rst = 1'b1;
        push(32'd1, 32'd1, 32'd1);
        bus.in_done = 1'b1;
        push(32'd2, 32'd2, 32'd2);
        bus.in_done = 1'b0;
        total++; if ({bus.wr_count, bus.capture_done} !== {9'd0, 1'b0})
            begin bad++; $display("FAIL ar_idle_after_reset got=%0d,%b want=0,0", bus.wr_count, bus.capture_done); end
        do_arm();
        push(32'd6, 32'd0, 32'd0);
        total++; if ({bus.wr_count, bus.checksum} !== {9'd1, 32'd6})
            begin bad++; $display("FAIL ar_rearm_capture got=%0d,%h want=1,6", bus.wr_count, bus.checksum); end
    endtask

    task automatic test_arm_restart();
        do_arm();
        for (int i = 0; i < 4; i++) push(32'd50 + i, 32'd1, 32'd2);
        bus.arm = 1'b1;
        push(32'd99, 32'd98, 32'd97);
        bus.arm = 1'b0;
        total++; if ({bus.wr_count, bus.checksum, bus.capture_done} !== {9'd0, 32'd0, 1'b0})
            begin bad++; $display("FAIL rs_arm_with_valid got=%0d,%h,%b want=0,0,0", bus.wr_count, bus.checksum, bus.capture_done); end
        push(32'd5, 32'd6, 32'd7);
        total++; if ({bus.wr_count, bus.checksum} !== {9'd1, 32'd4})
            begin bad++; $display("FAIL rs_next_triple got=%0d,%h want=1,4", bus.wr_count, bus.checksum); end
        read_entry(8'd0);
        total++; if ({bus.rd_force_x, bus.rd_force_y, bus.rd_force_z} !== {32'd5, 32'd6, 32'd7})
            begin bad++; $display("FAIL rs_entry0 got=%0d,%0d,%0d want=5,6,7", bus.rd_force_x, bus.rd_force_y, bus.rd_force_z); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_valid_with_done();
        test_read_beyond();
        test_async_reset();
        test_arm_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
